// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP48A1 slice as a MAC for sum(a[i]*b[i]); operands reach dsp_a/dsp_b one cycle after acceptance.
// Operands stall on in_valid and bubbles hold P. The result is held in DONE until res_ready; start is ignored while busy.
module dsp_mac_sequencer #(
   parameter int LEN_W    = 16,
   parameter int PIPE_LAT = 3,
   parameter int OPM_DLY  = 1
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [17:0]       in_a,
   input  logic [17:0]       in_b,
   output logic [17:0]       dsp_a,
   output logic [17:0]       dsp_b,
   output logic [7:0]        dsp_opmode,
   output logic              dsp_cea,
   output logic              dsp_ceb,
   output logic              dsp_cem,
   output logic              dsp_cep,
   output logic              dsp_ceopmode,
   output logic              dsp_rstm,
   output logic              dsp_rstp,
   input  logic [47:0]       dsp_p,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [47:0]       res_data
);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_DONE} state_t;

   localparam logic [7:0] OPM_FIRST  = 8'h01;  // X=M, Z=0
   localparam logic [7:0] OPM_ACC    = 8'h09;  // X=M, Z=P
   localparam logic [7:0] OPM_HOLD   = 8'h08;  // X=0, Z=P
   localparam logic [7:0] DRAIN_LAST = 8'(PIPE_LAT);

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_inc;
   logic [7:0]       dcnt;
   logic             acc;

   // Stage 0 holds the OPMODE code of the operand slot on dsp_a/dsp_b this cycle.
   logic [7:0]       opm_sr [0:OPM_DLY];

   assign busy         = (state != S_IDLE);
   assign in_ready     = (state == S_FEED) && (cnt != len_q);
   assign acc          = in_valid && in_ready;
   assign cnt_inc      = cnt + LEN_W'(1);
   assign dsp_opmode   = opm_sr[OPM_DLY];
   assign dsp_ceb      = dsp_cea;
   assign dsp_cep      = dsp_cem;
   assign dsp_ceopmode = dsp_cem;
   assign dsp_rstp     = dsp_rstm;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state     <= S_IDLE;
         len_q     <= '0;
         cnt       <= '0;
         dcnt      <= '0;
         dsp_a     <= '0;
         dsp_b     <= '0;
         dsp_cea   <= 1'b0;
         dsp_cem   <= 1'b0;
         dsp_rstm  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         for (int i = 0; i <= OPM_DLY; i++) opm_sr[i] <= 8'h00;
      end else begin
         dsp_cea  <= 1'b0;
         dsp_rstm <= 1'b0;
         for (int i = 1; i <= OPM_DLY; i++) opm_sr[i] <= opm_sr[i-1];
         opm_sr[0] <= OPM_HOLD;
         case (state)
            S_IDLE: begin
               opm_sr[0] <= 8'h00;
               if (start) begin
                  len_q <= len;
                  cnt   <= '0;
                  if (len != '0) begin
                     state     <= S_CLR;
                     dsp_rstm  <= 1'b1;
                     dsp_cem   <= 1'b1;
                     opm_sr[0] <= OPM_HOLD;
                  end else begin
                     state     <= S_DONE;
                     res_valid <= 1'b1;
                     res_data  <= '0;
                  end
               end
            end
            S_CLR: state <= S_FEED;
            S_FEED: begin
               if (acc) begin
                  dsp_a     <= in_a;
                  dsp_b     <= in_b;
                  dsp_cea   <= 1'b1;
                  cnt       <= cnt_inc;
                  opm_sr[0] <= (cnt == '0) ? OPM_FIRST : OPM_ACC;
                  if (cnt_inc == len_q) begin
                     state <= S_DRAIN;
                     dcnt  <= '0;
                  end
               end
            end
            S_DRAIN: begin
               // Last operand was driven in the first DRAIN cycle; P holds it PIPE_LAT cycles later.
               if (dcnt == DRAIN_LAST) begin
                  state     <= S_DONE;
                  dsp_cem   <= 1'b0;
                  res_valid <= 1'b1;
                  res_data  <= dsp_p;
                  opm_sr[0] <= 8'h00;
               end else begin
                  dcnt <= dcnt + 8'd1;
               end
            end
            S_DONE: begin
               opm_sr[0] <= 8'h00;
               if (res_ready) begin
                  state     <= S_IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench: sequencer driving a behavioural DSP48A1 slice (A1/B1/M/P/OPMODE registered, no pre-adder).
module tb_dsp_mac_sequencer;

   logic        CLK;
   logic        RSTN;
   logic        start;
   logic [15:0] len;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_a, in_b;
   logic [17:0] dsp_a, dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rstm, dsp_rstp;
   logic [47:0] dsp_p;
   logic        res_valid;
   logic        res_ready;
   logic [47:0] res_data;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int cea_cnt = 0;

   dsp_mac_sequencer dut (
      .CLK(CLK), .RSTN(RSTN), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
      .dsp_ceopmode(dsp_ceopmode), .dsp_rstm(dsp_rstm), .dsp_rstp(dsp_rstp),
      .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Behavioural DSP48A1 slice with the register settings the sequencer assumes.
   logic [17:0] a1_r = '0;
   logic [17:0] b1_r = '0;
   logic [35:0] m_r = '0;
   logic [7:0]  opm_r = '0;
   logic [47:0] p_r = '0;
   logic [47:0] x_mux, z_mux;

   always_comb begin
      x_mux = '0;
      z_mux = '0;
      case (opm_r[1:0])
         2'b01:   x_mux = {{12{m_r[35]}}, m_r};
         2'b10:   x_mux = p_r;
         default: x_mux = '0;
      endcase
      if (opm_r[3:2] == 2'b10) z_mux = p_r;
   end

   always @(posedge CLK) begin
      if (dsp_cea) a1_r <= dsp_a;
      if (dsp_ceb) b1_r <= dsp_b;
      if (dsp_rstm) m_r <= '0;
      else if (dsp_cem) m_r <= {{18{a1_r[17]}}, a1_r} * {{18{b1_r[17]}}, b1_r};
      if (dsp_ceopmode) opm_r <= dsp_opmode;
      if (dsp_rstp) p_r <= '0;
      else if (dsp_cep) p_r <= x_mux + z_mux;
   end
   assign dsp_p = p_r;

   always @(posedge CLK) begin
      if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
      if (dsp_cea) cea_cnt <= cea_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [15:0] l);
      start = 1'b1;
      len   = l;
      @(negedge CLK);
      start = 1'b0;
      len   = '0;
   endtask

   task automatic send(input logic [17:0] a, input logic [17:0] b);
      int g = 0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      while (!in_ready && g < 20) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 20) chk("send_ready_timeout", 64'(g), 64'd0);
      @(negedge CLK);
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (!res_valid && n < 30) begin
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic take();
      res_ready = 1'b1;
      @(negedge CLK);
      res_ready = 1'b0;
      chk("res_valid_clears", 64'(res_valid), 64'd0);
      chk("idle_after_take", 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      int acc0;
      int cea0;
      RSTN = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; res_ready = 1'b0;
      repeat (3) @(negedge CLK);

      // Reset state
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_opmode", 64'(dsp_opmode), 64'd0);
      chk("rst_ce", 64'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rstm, dsp_rstp}), 64'd0);
      RSTN = 1'b1;
      @(negedge CLK);

      // 1: three back-to-back pairs
      acc0 = acc_cnt;
      start_job(16'd3);
      chk("t1_clr_rst", 64'({dsp_rstm, dsp_rstp}), 64'd3);
      chk("t1_clr_ce", 64'({dsp_cem, dsp_cep, dsp_ceopmode}), 64'd7);
      chk("t1_clr_busy", 64'(busy), 64'd1);
      @(negedge CLK);
      send(18'd2, 18'd3);
      send(18'd4, 18'd5);
      send(18'h3FFFF, 18'd7);
      in_valid = 1'b0;
      chk("t1_ready_drop", 64'(in_ready), 64'd0);
      wait_res(n);
      chk("t1_latency", 64'(n), 64'd4);
      chk("t1_result", 64'(res_data), 64'd19);
      chk("t1_accepts", 64'(acc_cnt - acc0), 64'd3);
      take();

      // 2: four (1,1) pairs with two idle cycles between them
      start_job(16'd4);
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         send(18'd1, 18'd1);
         in_valid = 1'b0;
         chk("t2_cea_slot", 64'(dsp_cea), 64'd1);
         if (i < 3) begin
            @(negedge CLK);
            chk("t2_cea_bubble", 64'(dsp_cea), 64'd0);
            chk("t2_opmode_elem", 64'(dsp_opmode), (i == 0) ? 64'h01 : 64'h09);
            @(negedge CLK);
            chk("t2_opmode_bubble", 64'(dsp_opmode), 64'h08);
         end
      end
      wait_res(n);
      chk("t2_result", 64'(res_data), 64'd4);
      take();

      // 3: zero-length job
      cea0 = cea_cnt;
      start_job(16'd0);
      chk("t3_res_valid", 64'(res_valid), 64'd1);
      chk("t3_res_data", 64'(res_data), 64'd0);
      take();
      chk("t3_no_cea", 64'(cea_cnt - cea0), 64'd0);

      // 4: full-scale operands, then a new job must start from a cleared P
      start_job(16'd2);
      @(negedge CLK);
      send(18'h1FFFF, 18'h1FFFF);
      send(18'h1FFFF, 18'h1FFFF);
      in_valid = 1'b0;
      wait_res(n);
      chk("t4_result_a", 64'(res_data), 64'd34359214082);
      take();
      start_job(16'd1);
      @(negedge CLK);
      chk("t4_p_cleared", 64'(dsp_p), 64'd0);
      send(18'h20000, 18'h1FFFF);
      in_valid = 1'b0;
      wait_res(n);
      chk("t4_result_b", 64'(res_data), 64'hFFFC_0002_0000);
      take();

      // 5: reset after the second of five accepts
      start_job(16'd5);
      @(negedge CLK);
      send(18'd6, 18'd6);
      send(18'd7, 18'd7);
      in_valid = 1'b0;
      RSTN = 1'b0;
      @(negedge CLK);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_in_ready", 64'(in_ready), 64'd0);
      chk("t5_res_data", 64'(res_data), 64'd0);
      chk("t5_outs", 64'({dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_cem, dsp_rstm, res_valid}), 64'd0);
      RSTN = 1'b1;
      repeat (6) @(negedge CLK);
      chk("t5_no_result", 64'(res_valid), 64'd0);
      start_job(16'd1);
      @(negedge CLK);
      send(18'd3, 18'd3);
      in_valid = 1'b0;
      wait_res(n);
      chk("t5_result", 64'(res_data), 64'd9);
      take();

      // 6: result held under backpressure, start ignored in DONE
      start_job(16'd1);
      @(negedge CLK);
      send(18'd2, 18'd5);
      in_valid = 1'b0;
      wait_res(n);
      chk("t6_result", 64'(res_data), 64'd10);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         len   = 16'd0;
         @(negedge CLK);
         chk("t6_hold_valid", 64'(res_valid), 64'd1);
         chk("t6_hold_data", 64'(res_data), 64'd10);
      end
      start = 1'b0;
      take();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
